timer_dev: RTL and testbench

//  Memory-mapped countdown timer on the CPU data bus, next to dm_4k. Decodes

---
 rtl/timer_dev.sv | 78 +++++++
 tb/tb_timer_dev.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer with one-shot/auto-reload modes
// and a maskable, sticky interrupt flag.
module timer_dev #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, CNT = 2'd2, INT = 2'd3;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [1:0] state_q, state_d;
  logic [3:0] ctrl_q, ctrl_d;
  logic [WIDTH-1:0] preset_q, preset_d, count_q, count_d;
  logic irq_flag_q, irq_flag_d;
  logic wr_ctrl, wr_preset, expire, en, reload;
  assign wr_ctrl = we && addr == 2'd0;
  assign wr_preset = we && addr == 2'd1;
  assign en = ctrl_q[0];
  assign reload = ctrl_q[2:1] == 2'b01;
  assign irq = irq_flag_q & ctrl_q[3];
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ctrl_d = ctrl_q;
    expire = 1'b0;
    case (state_q)
      IDLE: state_d = en ? LOAD : IDLE;
      LOAD: begin
        count_d = preset_q;
        state_d = en ? CNT : IDLE;
      end
      CNT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (count_q > ONE) begin
          count_d = count_q - ONE;
        end else begin
          count_d = '0;
          expire = 1'b1;
          state_d = INT;
        end
      end
      default: begin
        state_d = reload ? LOAD : IDLE;
        ctrl_d[0] = reload & ctrl_q[0];
      end
    endcase
    // a CPU write to CTRL overrides the one-shot EN clear in the same cycle
    if (wr_ctrl) ctrl_d = wdata[3:0];
  end
  always_comb begin
    preset_d = wr_preset ? wdata[WIDTH-1:0] : preset_q;
    irq_flag_d = expire | (irq_flag_q & ~(wr_ctrl | wr_preset));
    rdata = addr == 2'd0 ? {28'd0, ctrl_q} :
            addr == 2'd1 ? 32'(preset_q) :
            addr == 2'd2 ? 32'(count_q) : 32'd0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ctrl_q <= '0;
      preset_q <= '0;
      count_q <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q <= ctrl_d;
      preset_q <= preset_d;
      count_q <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end
endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: directed and random stimulus for timer_dev, checked against a
// time-based behavioural model of the countdown.
module tb_timer_dev;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic we = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic irq;
  int n_tests = 0;
  int n_fail = 0;
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_EXP = 3;
  logic [3:0] m_ctrl;
  logic [31:0] m_preset, m_count, m_load;
  longint m_k;
  bit m_flag;
  int m_ph;

  timer_dev dut (.clk(clk), .rst(rst), .addr(addr), .we(we), .wdata(wdata), .rdata(rdata), .irq(irq));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 4'd0;
    m_preset = 32'd0;
    m_count = 32'd0;
    m_load = 32'd0;
    m_k = 0;
    m_flag = 1'b0;
    m_ph = P_IDLE;
  endtask

  // count after k edges of counting is load-k, expiring at k = max(load,1)
  task automatic model_edge(input bit w, input logic [1:0] a, input logic [31:0] d);
    bit en, rl, set, clr;
    int nph;
    logic [3:0] nctrl;
    en = m_ctrl[0];
    rl = m_ctrl[2:1] == 2'b01;
    set = 1'b0;
    nph = m_ph;
    nctrl = m_ctrl;
    if (m_ph == P_IDLE) begin
      if (en) nph = P_LOAD;
    end else if (m_ph == P_LOAD) begin
      m_load = m_preset;
      m_k = 0;
      m_count = m_preset;
      nph = en ? P_RUN : P_IDLE;
    end else if (m_ph == P_RUN) begin
      if (!en) nph = P_IDLE;
      else begin
        m_k++;
        if (m_k >= ((m_load == 32'd0) ? 64'sd1 : longint'(m_load))) begin
          m_count = 32'd0;
          set = 1'b1;
          nph = P_EXP;
        end else m_count = m_load - 32'(m_k);
      end
    end else begin
      nph = rl ? P_LOAD : P_IDLE;
      if (!rl) nctrl[0] = 1'b0;
    end
    clr = w && (a == 2'd0 || a == 2'd1);
    if (w && a == 2'd0) nctrl = d[3:0];
    if (w && a == 2'd1) m_preset = d;
    m_flag = set || (m_flag && !clr);
    m_ctrl = nctrl;
    m_ph = nph;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1 v = rdata;
  endtask

  task automatic check_all();
    logic [31:0] v;
    rd(2'd0, v); chk("ctrl", v, {28'd0, m_ctrl});
    rd(2'd1, v); chk("preset", v, m_preset);
    rd(2'd2, v); chk("count", v, m_count);
    rd(2'd3, v); chk("rsvd", v, 32'd0);
    chk("irq", {31'd0, irq}, {31'd0, m_flag & m_ctrl[3]});
  endtask

  task automatic step(input bit w, input logic [1:0] a, input logic [31:0] d);
    we = w;
    addr = a;
    wdata = d;
    @(posedge clk);
    model_edge(w, a, d);
    #1 we = 1'b0;
    check_all();
  endtask

  task automatic pulse_reset();
    logic [31:0] v;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1 chk("rst_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), v);
      chk("rst_rdata", v, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    check_all();
  endtask

  initial begin
    logic [31:0] v, d;
    logic [1:0] a;
    int r;
    int exp3[7] = '{0, 3, 2, 1, 0, 0, 3};
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check_all();
    // one-shot, PRESET=5
    step(1'b1, 2'd1, 32'd5);
    step(1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 2'd0, 32'd0);
      rd(2'd2, v);
      chk("t2_count", v, 32'((k < 2) ? 0 : 7 - k));
      chk("t2_irq", {31'd0, irq}, {31'd0, k == 7});
    end
    step(1'b0, 2'd0, 32'd0);
    rd(2'd0, v); chk("t2_ctrl", v, 32'h8);
    chk("t2_irq_hold", {31'd0, irq}, 32'd1);
    repeat (3) step(1'b0, 2'd0, 32'd0);
    chk("t2_irq_hold2", {31'd0, irq}, 32'd1);
    step(1'b1, 2'd0, 32'h8);
    chk("t2_irq_clr", {31'd0, irq}, 32'd0);
    // auto-reload, PRESET=3
    step(1'b1, 2'd1, 32'd3);
    step(1'b1, 2'd0, 32'hB);
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 2'd0, 32'd0);
      rd(2'd2, v);
      chk("t3_count", v, 32'(exp3[k-1]));
      chk("t3_irq", {31'd0, irq}, {31'd0, k >= 5});
    end
    step(1'b1, 2'd1, 32'd3);
    chk("t3_irq_clr", {31'd0, irq}, 32'd0);
    rd(2'd2, v); chk("t5_count2", v, 32'd2);
    // mid-count PRESET change only applies at the next reload
    step(1'b1, 2'd1, 32'd100);
    rd(2'd2, v); chk("t5_count1", v, 32'd1);
    step(1'b0, 2'd0, 32'd0);
    rd(2'd2, v); chk("t5_count0", v, 32'd0);
    step(1'b0, 2'd0, 32'd0);
    step(1'b0, 2'd0, 32'd0);
    rd(2'd2, v); chk("t5_reload", v, 32'd100);
    // masked expiry
    step(1'b1, 2'd0, 32'h0);
    step(1'b0, 2'd0, 32'd0);
    step(1'b1, 2'd1, 32'd4);
    step(1'b1, 2'd0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 2'd0, 32'd0);
      chk("t4_irq_masked", {31'd0, irq}, 32'd0);
    end
    step(1'b1, 2'd0, 32'h8);
    chk("t4_irq_unmask", {31'd0, irq}, 32'd0);
    // writes to COUNT and reserved are ignored
    step(1'b1, 2'd2, 32'hFFFF);
    rd(2'd2, v); chk("t6_count", v, 32'd0);
    step(1'b1, 2'd3, 32'hFFFF_FFFF);
    rd(2'd3, v); chk("t6_rsvd", v, 32'd0);
    // reset during an active count
    step(1'b1, 2'd1, 32'd50);
    step(1'b1, 2'd0, 32'hB);
    repeat (5) step(1'b0, 2'd0, 32'd0);
    pulse_reset();
    repeat (3) step(1'b0, 2'd0, 32'd0);
    rd(2'd2, v); chk("t1_count", v, 32'd0);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd1 && $urandom_range(0, 9) != 0) d = $urandom_range(0, 8);
      if (r == 0) pulse_reset();
      else if (r < 25) step(1'b1, a, d);
      else step(1'b0, a, d);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
